// File: rtl/regfile_masked.sv
// -----------------------------------------------------------------------------
// regfile_masked
//   Register file with two combinational read ports, one bit-masked write port,
//   same-cycle write-to-read bypass, an optional hardwired-zero register 0, and
//   a sequential clear engine that zeroes one register per cycle.
//
// Ports
//   clock             : single clock, all state changes on the rising edge
//   ctrl_reset        : asynchronous active-high reset
//   ctrl_writeEnable  : write request this cycle
//   ctrl_writeReg     : write address
//   data_writeReg     : write data
//   data_writeMask    : per-bit write mask (1 = bit updated)
//   ctrl_readRegA/B   : read addresses
//   ctrl_clear        : start a sequential clear of all registers
//   data_readRegA/B   : read data (zero-latency)
//   busy              : high while the clear sequence runs
// -----------------------------------------------------------------------------
module regfile_masked #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic [WIDTH-1:0]  data_writeMask,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  input  logic              ctrl_clear,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB,
  output logic              busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Index width actually needed to address DEPTH entries; the address ports
  // may be wider so that out-of-range addresses can be presented.
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              wr_accept;
  logic [WIDTH-1:0]  wr_merged;

  // An address names a real, writable/readable register only if it is inside
  // the array and is not the hardwired zero register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_EXT) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Writes are suppressed during reset so the bypass cannot leak data onto
  // the read ports while everything is being held at zero.
  assign wr_accept = ctrl_writeEnable && !ctrl_reset && (state_q == ST_IDLE)
                     && addr_live(ctrl_writeReg);

  assign wr_merged = (mem_q[ctrl_writeReg[IDX_W-1:0]] & ~data_writeMask)
                   | (data_writeReg & data_writeMask);

  // Read port A: zero for dead addresses, bypassed merge value on a colliding
  // accepted write, stored contents otherwise.
  always_comb begin
    data_readRegA = '0;
    if (addr_live(ctrl_readRegA)) begin
      if (wr_accept && (ctrl_writeReg == ctrl_readRegA)) begin
        data_readRegA = wr_merged;
      end else begin
        data_readRegA = mem_q[ctrl_readRegA[IDX_W-1:0]];
      end
    end
  end

  // Read port B: same rules as port A, fully independent.
  always_comb begin
    data_readRegB = '0;
    if (addr_live(ctrl_readRegB)) begin
      if (wr_accept && (ctrl_writeReg == ctrl_readRegB)) begin
        data_readRegB = wr_merged;
      end else begin
        data_readRegB = mem_q[ctrl_readRegB[IDX_W-1:0]];
      end
    end
  end

  // Next-state logic for the register array, FSM and clear counter.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    mem_d   = mem_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_accept) begin
          mem_d[ctrl_writeReg[IDX_W-1:0]] = wr_merged;
        end
        // A coincident write lands at this edge; the clear starting at the
        // same edge later zeroes it in its turn.
        if (ctrl_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end

      ST_CLEAR: begin
        // ctrl_clear is deliberately not looked at here: no restart/extend.
        mem_d[cnt_q[IDX_W-1:0]] = '0;
        cnt_d                   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      // NOTE: the array is deliberately reset here because the register file
      // must read all-zero the instant reset asserts, which costs flops with
      // reset pins instead of a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the values from before this edge, independent of order.
      mem_q   <= mem_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decoded straight from the state flop, so busy is registered and never
  // combinationally follows ctrl_clear.
  assign busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_masked.sv
`timescale 1ns/1ps
module tb_regfile_masked;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 6;

  logic          clock;
  logic          ctrl_reset;
  logic          ctrl_writeEnable;
  logic [AW-1:0] ctrl_writeReg;
  logic [W-1:0]  data_writeReg;
  logic [W-1:0]  data_writeMask;
  logic [AW-1:0] ctrl_readRegA;
  logic [AW-1:0] ctrl_readRegB;
  logic          ctrl_clear;
  logic [W-1:0]  data_readRegA;
  logic [W-1:0]  data_readRegB;
  logic          busy;

  regfile_masked #(
    .WIDTH(W), .DEPTH(D), .ADDR_W(AW), .ZERO_REG(1)
  ) dut (
    .clock           (clock),
    .ctrl_reset      (ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg   (ctrl_writeReg),
    .data_writeReg   (data_writeReg),
    .data_writeMask  (data_writeMask),
    .ctrl_readRegA   (ctrl_readRegA),
    .ctrl_readRegB   (ctrl_readRegB),
    .ctrl_clear      (ctrl_clear),
    .data_readRegA   (data_readRegA),
    .data_readRegB   (data_readRegB),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int busy_cycles = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain array of register values plus a "clear in progress"
  // flag and the index of the next register the clear will wipe.
  // ---------------------------------------------------------------------------
  logic [W-1:0] model [D];
  bit           m_busy;
  int           m_idx;

  function automatic bit m_accept();
    return ctrl_writeEnable && !ctrl_reset && !m_busy
           && (int'(ctrl_writeReg) < D) && (ctrl_writeReg != 0);
  endfunction

  function automatic logic [W-1:0] m_merge();
    return (model[int'(ctrl_writeReg) % D] & ~data_writeMask) | (data_writeReg & data_writeMask);
  endfunction

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
    if (int'(a) >= D || a == 0) return '0;
    if (m_accept() && a == ctrl_writeReg) return m_merge();
    return model[int'(a)];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < D; i++) model[i] = '0;
    m_busy = 0;
    m_idx  = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  // Inputs must already be set (called at posedge+1).
  task automatic cycle();
    bit           acc;
    logic [W-1:0] mval;
    int           widx;
    @(negedge clock);
    check("rd_a", data_readRegA, m_read(ctrl_readRegA));
    check("rd_b", data_readRegB, m_read(ctrl_readRegB));
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    if (busy) busy_cycles++;
    acc  = m_accept();
    mval = m_merge();
    widx = int'(ctrl_writeReg);
    @(posedge clock);
    if (acc) model[widx] = mval;
    if (m_busy) begin
      model[m_idx] = '0;
      m_idx++;
      if (m_idx == D) m_busy = 0;
    end else if (ctrl_clear) begin
      m_busy = 1;
      m_idx  = 0;
    end
    #1;
  endtask

  task automatic do_write(input int a, input logic [W-1:0] d, input logic [W-1:0] m);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = AW'(a);
    data_writeReg    = d;
    data_writeMask   = m;
  endtask

  task automatic idle();
    ctrl_writeEnable = 1'b0;
    ctrl_clear       = 1'b0;
  endtask

  task automatic rand_inputs();
    int r;
    ctrl_writeEnable = ($urandom_range(0, 2) != 0);
    ctrl_writeReg    = AW'($urandom_range(0, 2**AW - 1));
    data_writeReg    = $urandom;
    r = $urandom_range(0, 3);
    data_writeMask   = (r == 0) ? '0 : (r == 1) ? '1 : W'($urandom);
    ctrl_readRegA    = ($urandom_range(0, 1) != 0) ? ctrl_writeReg : AW'($urandom_range(0, 2**AW - 1));
    ctrl_readRegB    = AW'($urandom_range(0, 2**AW - 1));
  endtask

  task automatic fill_all();
    for (int i = 1; i < D; i++) begin
      do_write(i, 32'h1000_0000 + W'(i * 32'h0101), '1);
      ctrl_readRegA = AW'(i);
      ctrl_readRegB = AW'(i - 1);
      cycle();
    end
    idle();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctrl_reset = 1'b1;
    ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
    data_writeMask = '0; ctrl_readRegA = '0; ctrl_readRegB = '0; ctrl_clear = 1'b0;
    m_reset();
    #12;
    // Reset state
    check("rst_busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      ctrl_readRegA = AW'(i * 13);
      ctrl_readRegB = AW'(i * 13 + 1);
      #1;
      check("rst_rd_a", data_readRegA, 32'h0);
      check("rst_rd_b", data_readRegB, 32'h0);
    end
    ctrl_reset = 1'b0;
    @(posedge clock); #1;

    // Masked merge on r5
    do_write(5, 32'hDEADBEEF, 32'hFFFF_FFFF); ctrl_readRegA = 5; cycle();
    do_write(5, 32'h0000_1234, 32'h0000_FFFF); cycle();
    idle(); #1;
    check("r5_merge", data_readRegA, 32'hDEAD1234);
    cycle();
    // All-zero mask is a no-op
    do_write(5, 32'hFFFF_FFFF, 32'h0); cycle();
    idle(); #1;
    check("r5_nomask", data_readRegA, 32'hDEAD1234);

    // Same-cycle bypass on r7
    do_write(7, 32'hA5A5A5A5, '1); ctrl_readRegA = 7; #1;
    check("r7_bypass", data_readRegA, 32'hA5A5A5A5);
    cycle();
    // Write to hardwired r0
    do_write(0, 32'hFFFF_FFFF, '1); ctrl_readRegA = 0; ctrl_readRegB = 7; cycle();
    idle(); #1;
    check("r0_zero", data_readRegA, 32'h0);
    cycle();

    // Out-of-range address 40
    do_write(40, 32'h1234_5678, '1); ctrl_readRegA = 40; ctrl_readRegB = 8; cycle();
    idle(); #1;
    check("oor_read", data_readRegA, 32'h0);
    check("oor_alias", data_readRegB, model[8]);
    cycle();

    // Full sequential clear with random (ignored) writes and a re-pulse
    fill_all();
    ctrl_clear = 1'b1; cycle();
    busy_cycles = 0;
    for (int j = 0; j < 36; j++) begin
      rand_inputs();
      ctrl_clear    = (j == 4);
      ctrl_readRegA = AW'(j % D);
      ctrl_readRegB = AW'((j + D - 1) % D);
      cycle();
    end
    idle();
    check("busy_len", busy_cycles, 32);

    // Clear coincident with a write to r3
    do_write(3, 32'h11, '1); ctrl_clear = 1'b1; ctrl_readRegA = 3; ctrl_readRegB = 4; cycle();
    idle();
    for (int j = 0; j < 34; j++) cycle();
    check("r3_after_clr", data_readRegA, 32'h0);

    // Reset mid-clear
    fill_all();
    ctrl_clear = 1'b1; cycle();
    idle();
    for (int j = 0; j < 5; j++) cycle();
    #2;
    ctrl_reset = 1'b1;
    #1;
    m_reset();
    check("midclr_busy", {31'b0, busy}, 32'h0);
    for (int a = 0; a < 2**AW; a++) begin
      ctrl_readRegA = AW'(a);
      ctrl_readRegB = AW'(2**AW - 1 - a);
      #1;
      check("midclr_rd_a", data_readRegA, 32'h0);
      check("midclr_rd_b", data_readRegB, 32'h0);
    end
    do_write(2, 32'h55, '1); ctrl_readRegA = 2; #1;
    check("rst_no_bypass", data_readRegA, 32'h0);
    @(posedge clock); #1;
    ctrl_reset = 1'b0;
    cycle();
    idle(); #1;
    check("r2_after_rst", data_readRegA, 32'h55);
    cycle();

    // Randomized traffic
    for (int j = 0; j < 600; j++) begin
      rand_inputs();
      ctrl_clear = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle();
    for (int j = 0; j < 34; j++) cycle();

    // Final sweep of every address
    for (int a = 0; a < 2**AW; a++) begin
      ctrl_readRegA = AW'(a);
      ctrl_readRegB = AW'(2**AW - 1 - a);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_masked.md
REGFILE_MASKED -- requirements
Module: regfile_masked

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers.
REQ-003 SHALL have parameter ADDR_W, default 5, address width; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero.
REQ-005 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port ctrl_reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port ctrl_writeEnable  input  1  write request this cycle.
REQ-008 SHALL have port ctrl_writeReg  input  ADDR_W  write address.
REQ-009 SHALL have port data_writeReg  input  WIDTH  write data.
REQ-010 SHALL have port data_writeMask  input  WIDTH  per-bit write mask, 1 = bit updated.
REQ-011 SHALL have port ctrl_readRegA  input  ADDR_W  read address, port A.
REQ-012 SHALL have port ctrl_readRegB  input  ADDR_W  read address, port B.
REQ-013 SHALL have port ctrl_clear  input  1  request sequential clear of all registers.
REQ-014 SHALL have port data_readRegA  output  WIDTH  read data, port A.
REQ-015 SHALL have port data_readRegB  output  WIDTH  read data, port B.
REQ-016 SHALL have port busy  output  1  high while clear sequence runs.

Function
REQ-017 SHALL accept a write when ctrl_writeEnable=1, FSM in IDLE, ctrl_writeReg < DEPTH, and not (ZERO_REG=1 and ctrl_writeReg=0); otherwise drop the write silently.
REQ-018 SHALL update an accepted register at the next rising edge as new = (old AND NOT data_writeMask) OR (data_writeReg AND data_writeMask).
REQ-019 SHALL treat data_writeMask = all zeros as a no-op write; all ones = full overwrite.
REQ-020 SHALL provide combinational reads, zero-cycle latency, on both ports independently.
REQ-021 SHALL bypass: if a write is accepted this cycle to the address being read, that port returns the merged value of REQ-018, not the stored value.
REQ-022 SHALL return zero for a read address >= DEPTH, and for address 0 when ZERO_REG=1.
REQ-023 SHALL implement FSM states IDLE and CLEAR; IDLE -> CLEAR on rising edge with ctrl_clear=1; CLEAR -> IDLE on the edge that clears index DEPTH-1.
REQ-024 SHALL in CLEAR zero exactly one register per cycle, indices 0 to DEPTH-1 ascending, using an internal ADDR_W-bit counter reset to 0 on CLEAR entry.
REQ-025 SHALL drive busy=1 exactly while in CLEAR, DEPTH cycles total; busy is registered, not combinational from ctrl_clear.
REQ-026 SHALL ignore ctrl_clear while in CLEAR; no restart, no extension.
REQ-027 SHALL ignore all writes while in CLEAR; bypass SHALL NOT apply to rejected writes.
REQ-028 SHALL, when ctrl_clear and an acceptable write coincide in IDLE, perform the write at that edge and enter CLEAR at the same edge; the clear later zeroes the written register.
REQ-029 SHALL during CLEAR return current stored contents on reads, including not-yet-cleared registers.

Reset
REQ-030 SHALL on ctrl_reset=1, immediately and independent of clock, zero all registers, set FSM to IDLE, clear counter to 0, busy=0.
REQ-031 SHALL therefore read zero on both ports at every address while reset is asserted.
REQ-032 SHALL abort a clear in progress on reset; after release, FSM in IDLE and writes accepted on the first rising edge.

Verification
REQ-033 SHALL cover: write 0xDEADBEEF to r5, mask 0xFFFFFFFF, then mask 0x0000FFFF data 0x00001234 -> r5 reads 0xDEAD1234.
REQ-034 SHALL cover: same-cycle write r7=0xA5A5A5A5 full mask with readRegA=7 -> data_readRegA=0xA5A5A5A5 before the edge; write to r0 with ZERO_REG=1 -> r0 reads 0.
REQ-035 SHALL cover: fill r1..r31 nonzero, pulse ctrl_clear -> busy high exactly 32 cycles, r(k) reads 0 from cycle k+1 onward, writes in that window have no effect.
REQ-036 SHALL cover: ctrl_clear coincident with write r3=0x11 -> r3 reads 0x11 during cycles 1..3 of clear, then 0 after its clear cycle.
REQ-037 SHALL cover: assert ctrl_reset mid-clear between clock edges -> busy=0 and all reads 0 immediately; after release, write r2=0x55 on first edge -> r2 reads 0x55.
REQ-038 SHALL cover: read address 40 with DEPTH=32, ADDR_W=6 -> reads 0; write to address 40 changes no register.
